// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - RV32IC fetch aligner: word fetch, halfword buffer, whole-instruction output
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_rvalid_i,
    input  logic [31:0] fetch_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_c_o
);

    localparam logic [31:0] PC0 = RESET_PC & ~32'h1;
    localparam logic [31:0] FA0 = RESET_PC & ~32'h3;

    logic [15:0] hw_q [3];
    logic [15:0] hw_d [3];
    logic [1:0]  cnt_q, cnt_cons, cnt_d;
    logic [31:0] buf_pc_q, faddr_q;
    logic        outstanding_q, discard_q, skip_low_q;
    logic        is_c, consume, rsp, append, issue, overflow;

    assign is_c          = hw_q[0][1:0] != 2'b11;
    assign instr_c_o     = (cnt_q != 2'd0) && is_c;
    assign instr_valid_o = instr_c_o || ((cnt_q >= 2'd2) && !is_c);
    assign instr_o       = !instr_valid_o ? 32'h0 :
                           (is_c ? {16'h0000, hw_q[0]} : {hw_q[1], hw_q[0]});
    assign instr_pc_o    = buf_pc_q;

    assign consume = instr_valid_o && instr_ready_i;
    assign rsp     = fetch_rvalid_i && outstanding_q;
    assign append  = rsp && !discard_q;

    // Consume shifts first, then the response lands at the reduced count.
    always_comb begin
        hw_d     = hw_q;
        cnt_cons = cnt_q;
        overflow = 1'b0;
        if (consume) begin
            if (is_c) begin
                hw_d[0]  = hw_q[1];
                hw_d[1]  = hw_q[2];
                cnt_cons = cnt_q - 2'd1;
            end else begin
                hw_d[0]  = hw_q[2];
                cnt_cons = cnt_q - 2'd2;
            end
        end
        cnt_d = cnt_cons;
        if (append) begin
            if (skip_low_q) begin
                case (cnt_cons)
                    2'd0:    hw_d[0] = fetch_rdata_i[31:16];
                    2'd1:    hw_d[1] = fetch_rdata_i[31:16];
                    2'd2:    hw_d[2] = fetch_rdata_i[31:16];
                    default: overflow = 1'b1;
                endcase
                cnt_d = cnt_cons + 2'd1;
            end else begin
                case (cnt_cons)
                    2'd0: begin
                        hw_d[0] = fetch_rdata_i[15:0];
                        hw_d[1] = fetch_rdata_i[31:16];
                    end
                    2'd1: begin
                        hw_d[1] = fetch_rdata_i[15:0];
                        hw_d[2] = fetch_rdata_i[31:16];
                    end
                    default: overflow = 1'b1;
                endcase
                cnt_d = cnt_cons + 2'd2;
            end
        end
    end

    assign issue = !outstanding_q && !redirect_i && (cnt_cons <= 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hw_q          <= '{default: 16'h0};
            cnt_q         <= 2'd0;
            buf_pc_q      <= PC0;
            faddr_q       <= FA0;
            skip_low_q    <= RESET_PC[1];
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            fetch_req_o   <= 1'b0;
            fetch_addr_o  <= FA0;
        end else if (redirect_i) begin
            // A response still in flight stays tracked so it can be dropped on arrival.
            cnt_q         <= 2'd0;
            buf_pc_q      <= redirect_pc_i & ~32'h1;
            faddr_q       <= redirect_pc_i & ~32'h3;
            skip_low_q    <= redirect_pc_i[1];
            discard_q     <= outstanding_q && !fetch_rvalid_i;
            outstanding_q <= outstanding_q && !fetch_rvalid_i;
            fetch_req_o   <= 1'b0;
        end else begin
            hw_q        <= hw_d;
            cnt_q       <= cnt_d;
            fetch_req_o <= issue;
            if (consume) begin
                buf_pc_q <= buf_pc_q + (is_c ? 32'd2 : 32'd4);
            end
            if (rsp) begin
                outstanding_q <= 1'b0;
                if (discard_q) begin
                    discard_q <= 1'b0;
                end else begin
                    skip_low_q <= 1'b0;
                end
            end
            if (issue) begin
                outstanding_q <= 1'b1;
                fetch_addr_o  <= faddr_q;
                faddr_q       <= faddr_q + 32'd4;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(overflow && !redirect_i));

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - directed self-checking bench for fetch_aligner
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_rvalid = 1'b0;
    logic [31:0] fetch_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid_o;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_c_o;

    int vectors = 0;
    int miscompares = 0;
    int lat = 1;
    logic [31:0] mem [logic [31:0]];

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req_o    (fetch_req_o),
        .fetch_addr_o   (fetch_addr_o),
        .fetch_rvalid_i (fetch_rvalid),
        .fetch_rdata_i  (fetch_rdata),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_c_o      (instr_c_o)
    );

    always #5 clk = ~clk;

    // Unprogrammed words hold compressed halfwords whose value encodes their own PC.
    function automatic logic [15:0] hw(input logic [31:0] pc);
        return 16'(pc * 32'd2 + 32'd1);
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {hw(a + 32'd2), hw(a)};
    endfunction

    // Memory: request seen in cycle k answers with rvalid in cycle k+lat.
    bit          pend = 1'b0;
    int          cd = 0;
    logic [31:0] paddr = 32'h0;
    always @(negedge clk) begin
        fetch_rvalid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cd = cd - 1;
                if (cd == 0) begin
                    fetch_rvalid = 1'b1;
                    fetch_rdata  = rd(paddr);
                    pend         = 1'b0;
                end
            end
            if (fetch_req_o) begin
                pend  = 1'b1;
                paddr = fetch_addr_o;
                cd    = lat;
            end
        end
    end

    task automatic do_reset(input int l);
        @(negedge clk);
        rst_n       = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b1;
        lat         = l;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic next_instr(output logic [31:0] i, output logic [31:0] pc,
                              output logic c, output bit ok);
        ok = 1'b0; i = 32'h0; pc = 32'h0; c = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (instr_valid_o && instr_ready) begin
                i = instr_o; pc = instr_pc_o; c = instr_c_o; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (fetch_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_c_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: req=%b valid=%b c=%b, required 0 0 0", fetch_req_o, instr_valid_o, instr_c_o);
        end
        vectors++;
        if (fetch_addr_o !== 32'h0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%h instr=%h pc=%h, required 0 0 0", fetch_addr_o, instr_o, instr_pc_o);
        end
    endtask

    task automatic test_single_word;
        logic [31:0] i, pc; logic c; bit ok;
        mem.delete();
        mem[32'h0] = 32'h00A00093;
        do_reset(1);
        @(negedge clk);
        vectors++;
        if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL first_req: req=%b addr=%h, required 1 00000000", fetch_req_o, fetch_addr_o);
        end
        @(negedge clk);
        vectors++;
        if (fetch_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL req_pulse: req=%b, required 0", fetch_req_o);
        end
        next_instr(i, pc, c, ok);
        vectors++;
        if (!ok || i !== 32'h00A00093 || pc !== 32'h0 || c !== 1'b0) begin
            miscompares++;
            $display("FAIL word32: ok=%b instr=%h pc=%h c=%b, required 00a00093 00000000 0", ok, i, pc, c);
        end
    endtask

    task automatic test_compressed_pair;
        logic [31:0] i, pc; logic c; bit ok;
        mem.delete();
        mem[32'h0] = 32'h45054501;
        do_reset(1);
        next_instr(i, pc, c, ok);
        vectors++;
        if (!ok || i !== 32'h00004501 || pc !== 32'h0 || c !== 1'b1) begin
            miscompares++;
            $display("FAIL pair_lo: ok=%b instr=%h pc=%h c=%b, required 00004501 00000000 1", ok, i, pc, c);
        end
        @(negedge clk);
        vectors++;
        if (instr_valid_o !== 1'b1 || instr_o !== 32'h00004505 || instr_pc_o !== 32'h2 || instr_c_o !== 1'b1) begin
            miscompares++;
            $display("FAIL pair_hi: valid=%b instr=%h pc=%h c=%b, required 1 00004505 00000002 1",
                     instr_valid_o, instr_o, instr_pc_o, instr_c_o);
        end
        vectors++;
        if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h4) begin
            miscompares++;
            $display("FAIL pair_next_fetch: req=%b addr=%h, required 1 00000004", fetch_req_o, fetch_addr_o);
        end
    endtask

    task automatic test_straddle;
        logic [31:0] i, pc; logic c; bit ok;
        logic [31:0] exp_i [3];
        logic [31:0] exp_pc [3];
        logic        exp_c [3];
        exp_i  = '{32'h00004501, 32'h00A00093, 32'h00004505};
        exp_pc = '{32'h0, 32'h2, 32'h6};
        exp_c  = '{1'b1, 1'b0, 1'b1};
        mem.delete();
        mem[32'h0] = 32'h00934501;
        mem[32'h4] = 32'h450500A0;
        do_reset(1);
        for (int n = 0; n < 3; n++) begin
            next_instr(i, pc, c, ok);
            vectors++;
            if (!ok || i !== exp_i[n] || pc !== exp_pc[n] || c !== exp_c[n]) begin
                miscompares++;
                $display("FAIL straddle_%0d: ok=%b instr=%h pc=%h c=%b, required %h %h %b",
                         n, ok, i, pc, c, exp_i[n], exp_pc[n], exp_c[n]);
            end
        end
    endtask

    task automatic test_redirect;
        logic [31:0] i, pc; logic c; bit ok;
        bit found;
        mem.delete();
        mem[32'h8]   = 32'h11112222;
        mem[32'h100] = 32'h0093DEAD;
        mem[32'h104] = 32'h450500A0;
        do_reset(3);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (fetch_req_o && fetch_addr_o == 32'h8) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL redir_setup: req to 00000008 seen=%b, required 1", found);
            return;
        end
        redirect_pc = 32'h102;
        redirect    = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        vectors++;
        if (instr_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_valid: valid=%b, required 0", instr_valid_o);
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (fetch_req_o) found = 1'b1;
        end
        vectors++;
        if (!found || fetch_addr_o !== 32'h100) begin
            miscompares++;
            $display("FAIL redir_fetch: seen=%b addr=%h, required 1 00000100", found, fetch_addr_o);
        end
        next_instr(i, pc, c, ok);
        vectors++;
        if (!ok || i !== 32'h00A00093 || pc !== 32'h102 || c !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_first: ok=%b instr=%h pc=%h c=%b, required 00a00093 00000102 0", ok, i, pc, c);
        end
        next_instr(i, pc, c, ok);
        vectors++;
        if (!ok || i !== 32'h00004505 || pc !== 32'h106 || c !== 1'b1) begin
            miscompares++;
            $display("FAIL redir_second: ok=%b instr=%h pc=%h c=%b, required 00004505 00000106 1", ok, i, pc, c);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] i, pc, ep; logic c; bit ok;
        mem.delete();
        do_reset(1);
        for (int n = 0; n < 2; n++) begin
            next_instr(i, pc, c, ok);
            ep = 32'(2 * n);
            vectors++;
            if (!ok || i !== {16'h0, hw(ep)} || pc !== ep) begin
                miscompares++;
                $display("FAIL bp_pre_%0d: ok=%b instr=%h pc=%h, required %h %h", n, ok, i, pc, {16'h0, hw(ep)}, ep);
            end
        end
        @(posedge clk);
        #1 instr_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                vectors++;
                if (instr_valid_o !== 1'b1 || instr_o !== {16'h0, hw(32'h4)} || instr_pc_o !== 32'h4) begin
                    miscompares++;
                    $display("FAIL bp_hold_%0d: valid=%b instr=%h pc=%h, required 1 %h 00000004",
                             k, instr_valid_o, instr_o, instr_pc_o, {16'h0, hw(32'h4)});
                end
            end
            if (k >= 5) begin
                vectors++;
                if (fetch_req_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_noreq_%0d: req=%b, required 0", k, fetch_req_o);
                end
            end
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            next_instr(i, pc, c, ok);
            ep = 32'(4 + 2 * n);
            vectors++;
            if (!ok || i !== {16'h0, hw(ep)} || pc !== ep || c !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_resume_%0d: ok=%b instr=%h pc=%h c=%b, required %h %h 1",
                         n, ok, i, pc, c, {16'h0, hw(ep)}, ep);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] i, pc; logic c; bit ok;
        bit found;
        mem.delete();
        do_reset(1);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (fetch_req_o && instr_valid_o) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL arst_setup: busy cycle seen=%b, required 1", found);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (instr_valid_o !== 1'b0 || fetch_req_o !== 1'b0 || instr_pc_o !== 32'h0) begin
            miscompares++;
            $display("FAIL arst_drop: valid=%b req=%b pc=%h, required 0 0 00000000", instr_valid_o, fetch_req_o, instr_pc_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h0) begin
            miscompares++;
            $display("FAIL arst_refetch: req=%b addr=%h, required 1 00000000", fetch_req_o, fetch_addr_o);
        end
        next_instr(i, pc, c, ok);
        vectors++;
        if (!ok || i !== {16'h0, hw(32'h0)} || pc !== 32'h0 || c !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_first: ok=%b instr=%h pc=%h c=%b, required %h 00000000 1", ok, i, pc, c, {16'h0, hw(32'h0)});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_compressed_pair();
        test_straddle();
        test_redirect();
        test_backpressure();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
